// File: rtl/icw_command_sequencer_if.sv
// CPU-side bus and decoded command strobes of the interrupt controller front end.
// master drives the CPU cycle; slave is the command sequencer.
interface icw_command_sequencer_if;
  logic       chip_select_n;
  logic       read_enable_n;
  logic       write_enable_n;
  logic       address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       write_initial_command_word_1;
  logic       write_initial_command_word_2;
  logic       write_initial_command_word_3;
  logic       write_initial_command_word_4;
  logic       write_operation_control_word_1;
  logic       write_operation_control_word_2;
  logic       write_operation_control_word_3;
  logic       read;
  logic       initialized;
  logic [2:0] sequence_state;

  modport master (
    output chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
    input  internal_data_bus,
    input  write_initial_command_word_1, write_initial_command_word_2,
    input  write_initial_command_word_3, write_initial_command_word_4,
    input  write_operation_control_word_1, write_operation_control_word_2,
    input  write_operation_control_word_3,
    input  read, initialized, sequence_state
  );

  modport slave (
    input  chip_select_n, read_enable_n, write_enable_n, address, data_bus_in,
    output internal_data_bus,
    output write_initial_command_word_1, write_initial_command_word_2,
    output write_initial_command_word_3, write_initial_command_word_4,
    output write_operation_control_word_1, write_operation_control_word_2,
    output write_operation_control_word_3,
    output read, initialized, sequence_state
  );
endinterface

// File: rtl/icw_command_sequencer.sv
// Captures CPU writes and, one cycle after write_enable_n rises, pulses exactly one
// ICW/OCW strobe while walking the ICW1 -> ICW2 -> [ICW3] -> [ICW4] init sequence.
module icw_command_sequencer #(
  parameter bit ALLOW_OCW_BEFORE_INIT = 1'b0
) (
  input logic                    clock,
  input logic                    reset,
  icw_command_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    UNINIT    = 3'd0,
    WAIT_ICW2 = 3'd1,
    WAIT_ICW3 = 3'd2,
    WAIT_ICW4 = 3'd3,
    READY     = 3'd4
  } state_t;

  localparam logic [6:0] STB_ICW1 = 7'b000_0001;
  localparam logic [6:0] STB_ICW2 = 7'b000_0010;
  localparam logic [6:0] STB_ICW3 = 7'b000_0100;
  localparam logic [6:0] STB_ICW4 = 7'b000_1000;
  localparam logic [6:0] STB_OCW1 = 7'b001_0000;
  localparam logic [6:0] STB_OCW2 = 7'b010_0000;
  localparam logic [6:0] STB_OCW3 = 7'b100_0000;

  state_t     state, state_d;
  logic [7:0] data_q;
  logic       addr_q;
  logic       wr_pending;
  logic       prev_write_n;
  logic       icw4_needed, icw4_needed_d;
  logic       single_mode, single_mode_d;
  logic       initialized_q;
  logic [6:0] strobe_q, strobe_d;
  logic       capture;
  logic       wr_end;
  logic       ocw_allowed;

  assign capture     = ~bus.chip_select_n & ~bus.write_enable_n;
  // End of write is the rising edge of write_enable_n, whatever chip_select_n does by then.
  assign wr_end      = ~prev_write_n & bus.write_enable_n & wr_pending;
  assign ocw_allowed = (state == READY) || ((state == UNINIT) && ALLOW_OCW_BEFORE_INIT);

  always_ff @(posedge clock) begin
    if (reset) state <= UNINIT;
    else       state <= state_d;
  end

  always_comb begin
    state_d       = state;
    strobe_d      = '0;
    icw4_needed_d = icw4_needed;
    single_mode_d = single_mode;
    if (wr_end) begin
      if (!addr_q && data_q[4]) begin
        strobe_d      = STB_ICW1;
        icw4_needed_d = data_q[0];
        single_mode_d = data_q[1];
        state_d       = WAIT_ICW2;
      end else if (addr_q) begin
        case (state)
          WAIT_ICW2: begin
            strobe_d = STB_ICW2;
            if (!single_mode)     state_d = WAIT_ICW3;
            else if (icw4_needed) state_d = WAIT_ICW4;
            else                  state_d = READY;
          end
          WAIT_ICW3: begin
            strobe_d = STB_ICW3;
            state_d  = icw4_needed ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            strobe_d = STB_ICW4;
            state_d  = READY;
          end
          READY:   strobe_d = STB_OCW1;
          UNINIT:  if (ALLOW_OCW_BEFORE_INIT) strobe_d = STB_OCW1;
          default: state_d = UNINIT;
        endcase
      end else if (ocw_allowed) begin
        strobe_d = data_q[3] ? STB_OCW3 : STB_OCW2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q        <= '0;
      addr_q        <= 1'b0;
      wr_pending    <= 1'b0;
      prev_write_n  <= 1'b1;
      icw4_needed   <= 1'b0;
      single_mode   <= 1'b0;
      initialized_q <= 1'b0;
      strobe_q      <= '0;
    end else begin
      prev_write_n  <= bus.write_enable_n;
      if (capture) begin
        data_q     <= bus.data_bus_in;
        addr_q     <= bus.address;
        wr_pending <= 1'b1;
      end else if (wr_end) begin
        wr_pending <= 1'b0;
      end
      icw4_needed   <= icw4_needed_d;
      single_mode   <= single_mode_d;
      initialized_q <= (state_d == READY);
      strobe_q      <= strobe_d;
    end
  end

  assign bus.internal_data_bus              = data_q;
  assign bus.write_initial_command_word_1   = strobe_q[0];
  assign bus.write_initial_command_word_2   = strobe_q[1];
  assign bus.write_initial_command_word_3   = strobe_q[2];
  assign bus.write_initial_command_word_4   = strobe_q[3];
  assign bus.write_operation_control_word_1 = strobe_q[4];
  assign bus.write_operation_control_word_2 = strobe_q[5];
  assign bus.write_operation_control_word_3 = strobe_q[6];
  assign bus.read                           = ~bus.chip_select_n & ~bus.read_enable_n;
  assign bus.initialized                    = initialized_q;
  assign bus.sequence_state                 = state;
endmodule
